// File: rtl/m_blink_ctrl_pkg.sv
// Shared constants for the LED blink controller: mode encodings and channel index width.
package m_blink_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeOn    = 2'd1,
        ModeBlink = 2'd2,
        ModePwm   = 2'd3
    } mode_e;

    localparam int unsigned ChIdxW = 4;

endpackage

// File: rtl/m_blink_ch.sv
// One LED channel: config registers, blink counter/phase and the registered LED drive.
module m_blink_ch
    import m_blink_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PWM_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_half,
    input  logic [PWM_W-1:0] i_duty,
    input  logic             i_tick,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    mode_e            r_mode;
    logic [CNT_W-1:0] r_half;
    logic [PWM_W-1:0] r_duty;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_led;

    logic [CNT_W-1:0] w_half_sat;
    logic             w_wrap;
    logic             w_led_d;

    assign w_half_sat = (i_half == '0) ? CntOne : i_half;
    assign w_wrap     = (r_cnt == (r_half - CntOne));

    // A write wins over a coincident tick: the tick is simply not consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode  <= ModeOff;
            r_half  <= CntOne;
            r_duty  <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_we) begin
            r_mode  <= mode_e'(i_mode);
            r_half  <= w_half_sat;
            r_duty  <= i_duty;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_mode == ModeBlink) begin
            if (i_tick) begin
                if (w_wrap) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + CntOne;
                end
            end
        end else begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end
    end

    always_comb begin
        w_led_d = 1'b0;
        unique case (r_mode)
            ModeOff:   w_led_d = 1'b0;
            ModeOn:    w_led_d = 1'b1;
            ModeBlink: w_led_d = r_phase;
            ModePwm:   w_led_d = (i_pwm_cnt < r_duty);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_d;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/m_blink_ctrl.sv
// Multi-channel LED controller: shared prescaler and PWM counter feeding NCH channel slices.
module m_blink_ctrl
    import m_blink_ctrl_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DIV   = 100000000,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PWM_W = 8
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_we,
    input  logic [ChIdxW-1:0] w_ch,
    input  logic [1:0]        w_mode,
    input  logic [CNT_W-1:0]  w_half,
    input  logic [PWM_W-1:0]  w_duty,
    output logic [NCH-1:0]    w_led,
    output logic              w_tick
);

    localparam logic [CNT_W-1:0] PreLast = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] PreOne  = CNT_W'(1);
    localparam logic [PWM_W-1:0] PwmOne  = PWM_W'(1);

    logic [CNT_W-1:0] r_pre;
    logic [PWM_W-1:0] r_pwm;
    logic             r_tick;
    logic             w_pre_last;

    assign w_pre_last = (r_pre == PreLast);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pre  <= '0;
            r_pwm  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_pre_last ? '0 : (r_pre + PreOne);
            r_pwm  <= r_pwm + PwmOne;
            r_tick <= w_pre_last;
        end
    end

    assign w_tick = r_tick;

    // Out-of-range channel indices match no slice, so those writes are dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = w_we && (w_ch == ChIdxW'(g));

        m_blink_ch #(
            .CNT_W (CNT_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .i_clk     (w_clk),
            .i_rst     (w_rst),
            .i_we      (w_sel),
            .i_mode    (w_mode),
            .i_half    (w_half),
            .i_duty    (w_duty),
            .i_tick    (r_tick),
            .i_pwm_cnt (r_pwm),
            .o_led     (w_led[g])
        );
    end

endmodule

// File: tb/tb_m_blink_ctrl.sv
// Directed bench for m_blink_ctrl at DIV=4, NCH=4, PWM_W=4; cyc counts edges since reset release.
module tb_m_blink_ctrl;
    import m_blink_ctrl_pkg::*;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DIV   = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PWM_W = 4;

    logic             w_clk = 1'b0;
    logic             w_rst = 1'b1;
    logic             w_we = 1'b0;
    logic [3:0]       w_ch = '0;
    logic [1:0]       w_mode = '0;
    logic [CNT_W-1:0] w_half = '0;
    logic [PWM_W-1:0] w_duty = '0;
    logic [NCH-1:0]   w_led;
    logic             w_tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    m_blink_ctrl #(
        .NCH   (NCH),
        .DIV   (DIV),
        .CNT_W (CNT_W),
        .PWM_W (PWM_W)
    ) dut (
        .w_clk  (w_clk),
        .w_rst  (w_rst),
        .w_we   (w_we),
        .w_ch   (w_ch),
        .w_mode (w_mode),
        .w_half (w_half),
        .w_duty (w_duty),
        .w_led  (w_led),
        .w_tick (w_tick)
    );

    initial forever #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
        cyc++;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wr(input logic [3:0] ch, input mode_e m, input logic [CNT_W-1:0] half,
                      input logic [PWM_W-1:0] duty);
        w_we   = 1'b1;
        w_ch   = ch;
        w_mode = m;
        w_half = half;
        w_duty = duty;
        step();
        w_we   = 1'b0;
    endtask

    // pwm counter value seen at edge e is (e-1) mod 16 since it clears in reset
    task automatic pwm_window(input logic [PWM_W-1:0] duty, input int exp_high);
        int high = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("pwm_bit", 32'(w_led[1]), 32'(((cyc - 1) % 16) < int'(duty)));
            high += int'(w_led[1]);
        end
        chk("pwm_count", high, exp_high);
    endtask

    initial begin
        // reset held for 3 edges
        repeat (3) step();
        chk("rst_led", 32'(w_led), 32'h0);
        chk("rst_tick", 32'(w_tick), 32'h0);
        w_rst = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("tick_period", 32'(w_tick), 32'((cyc % 4) == 0));
        end

        // ON / OFF on channel 2
        wr(4'd2, ModeOn, 32'd1, 4'd0);
        chk("on_latency", 32'(w_led), 32'h0);
        step();
        chk("on_led", 32'(w_led), 32'b0100);
        wr(4'd2, ModeOff, 32'd1, 4'd0);
        chk("off_latency", 32'(w_led), 32'b0100);
        step();
        chk("off_led", 32'(w_led), 32'h0);

        // BLINK ch0 half=3 written at edge 18: led[0] toggles every 12 edges from edge 30
        goto_edge(17);
        wr(4'd0, ModeBlink, 32'd3, 4'd0);
        while (cyc < 57) begin
            step();
            chk("blink_run", 32'(w_led[0]), 32'(((cyc - 18) / 12) % 2));
        end
        // mid-period rewrite at edge 58: goes low, next rise a full 12 edges later
        wr(4'd0, ModeBlink, 32'd3, 4'd0);
        chk("blink_rewrite_lat", 32'(w_led[0]), 32'h1);
        while (cyc < 70) begin
            step();
            chk("blink_restart", 32'(w_led[0]), 32'(cyc >= 70));
        end
        wr(4'd0, ModeOff, 32'd1, 4'd0);

        // PWM on ch1
        wr(4'd1, ModePwm, 32'd1, 4'd5);
        pwm_window(4'd5, 5);
        wr(4'd1, ModePwm, 32'd1, 4'd0);
        pwm_window(4'd0, 0);
        wr(4'd1, ModePwm, 32'd1, 4'd15);
        pwm_window(4'd15, 15);
        wr(4'd1, ModeOff, 32'd1, 4'd0);

        // out-of-range channel write is ignored
        wr(4'd2, ModeOn, 32'd1, 4'd0);
        wr(4'd7, ModeOn, 32'd1, 4'd0);
        step();
        chk("ch7_ignored_a", 32'(w_led), 32'b0100);
        step();
        chk("ch7_ignored_b", 32'(w_led), 32'b0100);
        wr(4'd2, ModeOff, 32'd1, 4'd0);

        // half=0 acts as half=1: written at edge 130, toggles on every tick
        goto_edge(129);
        wr(4'd0, ModeBlink, 32'd0, 4'd0);
        goto_edge(133);
        chk("half0_a", 32'(w_led[0]), 32'h0);
        step();
        chk("half0_b", 32'(w_led[0]), 32'h1);
        goto_edge(137);
        chk("half0_c", 32'(w_led[0]), 32'h1);
        step();
        chk("half0_d", 32'(w_led[0]), 32'h0);
        goto_edge(142);
        chk("half0_e", 32'(w_led[0]), 32'h1);

        // write coincident with a tick on ch3 (edge 157): tick dropped, phase stays 0
        goto_edge(145);
        wr(4'd3, ModeBlink, 32'd1, 4'd0);
        goto_edge(150);
        chk("coinc_pre", 32'(w_led[3]), 32'h1);
        goto_edge(156);
        wr(4'd3, ModeBlink, 32'd1, 4'd0);
        step();
        chk("coinc_phase0", 32'(w_led[3]), 32'h0);
        goto_edge(161);
        chk("coinc_hold", 32'(w_led[3]), 32'h0);
        step();
        chk("coinc_next", 32'(w_led[3]), 32'h1);

        // reset with a simultaneous write while channels blink
        w_rst  = 1'b1;
        w_we   = 1'b1;
        w_ch   = 4'd2;
        w_mode = ModeOn;
        step();
        chk("rstwe_led", 32'(w_led), 32'h0);
        chk("rstwe_tick", 32'(w_tick), 32'h0);
        w_rst = 1'b0;
        w_we  = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_led", 32'(w_led), 32'h0);
            chk("post_rst_tick", 32'(w_tick), 32'((cyc % 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
